// File: rtl/fir_pkg.sv
// Shared defaults and loader state encoding for the FIR coefficient path.
package fir_pkg;

  localparam int unsigned NumTapsDefault    = 10;
  localparam int unsigned DataWidthDefault  = 8;
  localparam int unsigned IndexWidthDefault = 4;

  // StCheck is only reachable when the checksum feature is built in.
  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StLoad  = 2'd1,
    StCheck = 2'd2,
    StDone  = 2'd3
  } loader_state_e;

endpackage

// File: rtl/fir_loader_checksum.sv
// Modulo-2^DataWidth running sum of the coefficient byte stream, with clear and add.
module fir_loader_checksum #(
  parameter int unsigned DataWidth = 8
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 clear_i,
  input  logic                 add_i,
  input  logic [DataWidth-1:0] data_i,
  output logic [DataWidth-1:0] sum_next_o
);

  logic [DataWidth-1:0] acc_q, acc_d;

  // Clear wins over add so a fresh load never inherits a stale sum.
  always_comb begin
    acc_d = acc_q;
    if (clear_i) begin
      acc_d = '0;
    end else if (add_i) begin
      acc_d = acc_q + data_i;
    end
  end

  // Accumulator register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      acc_q <= '0;
    end else begin
      acc_q <= acc_d;
    end
  end

  // Sum including the byte currently on the input; used to judge the checksum byte.
  assign sum_next_o = acc_q + data_i;

endmodule

// File: rtl/fir_coefficient_loader.sv
// Streams NUM_TAPS signed coefficient bytes into a downstream FIR as indexed write strobes.
// Optional feature macro: FIR_COEF_CHECKSUM_EN adds a trailing checksum byte and the Error flag.
module fir_coefficient_loader
  import fir_pkg::*;
#(
  parameter int unsigned NUM_TAPS    = NumTapsDefault,
  parameter int unsigned DATA_WIDTH  = DataWidthDefault,
  parameter int unsigned INDEX_WIDTH = IndexWidthDefault
) (
  input  logic                         Clk,
  input  logic                         Reset,
  input  logic                         Start,
  input  logic                         Abort,
  input  logic signed [DATA_WIDTH-1:0] InData,
  input  logic                         InValid,
  output logic                         InReady,
  output logic [INDEX_WIDTH-1:0]       CoefficientIndex,
  output logic signed [DATA_WIDTH-1:0] NewCoefficientValue,
  output logic                         CoefficientWriteEnable,
  output logic                         Busy,
  output logic                         Done,
  output logic                         Error
);

  loader_state_e state_q, state_d;

  logic [INDEX_WIDTH-1:0]        cnt_q, cnt_d;
  logic                          we_q, we_d;
  logic [INDEX_WIDTH-1:0]        idx_q, idx_d;
  logic signed [DATA_WIDTH-1:0]  val_q, val_d;
  logic                          done_q, done_d;
  logic                          xfer;
  logic                          last_tap;

  assign InReady  = (state_q == StLoad) || (state_q == StCheck);
  assign xfer     = InValid && InReady;
  assign last_tap = (cnt_q == INDEX_WIDTH'(NUM_TAPS - 1));

`ifdef FIR_COEF_CHECKSUM_EN
  logic                  error_q, error_d;
  logic                  acc_clear;
  logic                  acc_add;
  logic [DATA_WIDTH-1:0] sum_next;

  fir_loader_checksum #(
    .DataWidth (DATA_WIDTH)
  ) u_checksum (
    .clk_i      (Clk),
    .rst_ni     (Reset),
    .clear_i    (acc_clear),
    .add_i      (acc_add),
    .data_i     (InData),
    .sum_next_o (sum_next)
  );
`endif

  // Next-state, tap counter and registered strobe/pulse decode.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    we_d    = 1'b0;
    idx_d   = '0;
    val_d   = '0;
    done_d  = 1'b0;
`ifdef FIR_COEF_CHECKSUM_EN
    error_d   = error_q;
    acc_clear = 1'b0;
    acc_add   = 1'b0;
`endif
    unique case (state_q)
      StIdle: begin
        // The Done cycle still counts as busy, so a Start there is not taken.
        if (Start && !Abort && !done_q) begin
          state_d = StLoad;
          cnt_d   = '0;
`ifdef FIR_COEF_CHECKSUM_EN
          error_d   = 1'b0;
          acc_clear = 1'b1;
`endif
        end
      end
      StLoad: begin
        if (Abort) begin
          // Any byte presented alongside Abort is dropped.
          state_d = StIdle;
          cnt_d   = '0;
        end else if (xfer) begin
          we_d  = 1'b1;
          idx_d = cnt_q;
          val_d = InData;
`ifdef FIR_COEF_CHECKSUM_EN
          acc_add = 1'b1;
`endif
          if (last_tap) begin
            cnt_d = '0;
`ifdef FIR_COEF_CHECKSUM_EN
            state_d = StCheck;
`else
            state_d = StDone;
`endif
          end else begin
            cnt_d = cnt_q + INDEX_WIDTH'(1);
          end
        end
      end
`ifdef FIR_COEF_CHECKSUM_EN
      StCheck: begin
        if (Abort) begin
          state_d = StIdle;
        end else if (xfer) begin
          // All NUM_TAPS+1 bytes must sum to zero modulo 2^DATA_WIDTH.
          error_d = (sum_next != '0);
          done_d  = 1'b1;
          state_d = StDone;
        end
      end
`endif
      StDone: begin
        state_d = StIdle;
`ifndef FIR_COEF_CHECKSUM_EN
        // Done lands one cycle after the final write strobe.
        done_d = !Abort;
`endif
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // State and output registers; reset clears everything including a strobe in flight.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      we_q    <= 1'b0;
      idx_q   <= '0;
      val_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      idx_q   <= idx_d;
      val_q   <= val_d;
      done_q  <= done_d;
    end
  end

`ifdef FIR_COEF_CHECKSUM_EN
  // Error flag: cleared by an accepted Start, updated with Done, otherwise held.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      error_q <= 1'b0;
    end else begin
      error_q <= error_d;
    end
  end

  assign Error = error_q;
`else
  assign Error = 1'b0;
`endif

  assign CoefficientWriteEnable = we_q;
  assign CoefficientIndex       = idx_q;
  assign NewCoefficientValue    = val_q;
  assign Done                   = done_q;
  assign Busy                   = (state_q != StIdle) || done_q;

endmodule

// File: tb/tb_fir_coefficient_loader.sv
// Self-checking bench for fir_coefficient_loader: behavioural model plus directed literal checks.
// Honours FIR_COEF_CHECKSUM_EN the same way the design does.
module tb_fir_coefficient_loader;

  localparam int NT = 10;
`ifdef FIR_COEF_CHECKSUM_EN
  localparam bit Chk = 1'b1;
  localparam int NB  = NT + 1;
`else
  localparam bit Chk = 1'b0;
  localparam int NB  = NT;
`endif

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start, abort, in_valid;
  logic [7:0] in_data;
  logic       in_ready;
  logic [3:0] coef_idx;
  logic [7:0] coef_val;
  logic       coef_we, busy, done, error;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  typedef struct {int cyc; int idx; int val;} wr_t;
  wr_t        wr_log[$];
  int         done_log[$];
  int         fir_taps[16];
  logic [7:0] tx_q[$];

  fir_coefficient_loader dut (
    .Clk                    (clk),
    .Reset                  (rst_n),
    .Start                  (start),
    .Abort                  (abort),
    .InData                 (in_data),
    .InValid                (in_valid),
    .InReady                (in_ready),
    .CoefficientIndex       (coef_idx),
    .NewCoefficientValue    (coef_val),
    .CoefficientWriteEnable (coef_we),
    .Busy                   (busy),
    .Done                   (done),
    .Error                  (error)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
    checks++;
    if (act !== want) begin
      failures++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, want, cyc);
    end
  endtask

  // Reference model: phase 0 idle, 1 taking bytes, 2 waiting to pulse Done.
  int m_phase = 0, m_taken = 0, m_sum = 0;
  bit e_we = 0, e_done = 0, e_err = 0;
  int e_idx = 0, e_val = 0;
  bit was_done;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_phase = 0; m_taken = 0; m_sum = 0;
      e_we = 0; e_idx = 0; e_val = 0; e_done = 0; e_err = 0;
    end else begin
      was_done = e_done;
      e_we = 0; e_idx = 0; e_val = 0; e_done = 0;
      if (m_phase == 0) begin
        if (start && !abort && !was_done) begin
          m_phase = 1; m_taken = 0; m_sum = 0; e_err = 0;
        end
      end else if (abort) begin
        m_phase = 0; m_taken = 0;
      end else if (m_phase == 2) begin
        e_done = 1; m_phase = 0;
      end else if (in_valid) begin
        m_sum = (m_sum + int'(in_data)) % 256;
        if (m_taken < NT) begin
          e_we = 1; e_idx = m_taken; e_val = int'(in_data);
          m_taken++;
          if (m_taken == NT && !Chk) m_phase = 2;
        end else begin
          e_err = (m_sum != 0); e_done = 1; m_phase = 0;
        end
      end
    end
  end

  // Every-cycle comparison against the model.
  always @(negedge clk) begin
    chk("ready", in_ready, m_phase == 1);
    chk("we",    coef_we,  e_we);
    chk("idx",   coef_idx, e_idx);
    chk("val",   coef_val, e_val);
    chk("done",  done,     e_done);
    chk("busy",  busy,     (m_phase != 0) || e_done);
    chk("error", error,    e_err);
  end

  // Downstream FIR stand-in: capture strobes and Done pulses.
  always @(negedge clk) begin
    if (coef_we === 1'b1) begin
      wr_log.push_back('{cyc, int'(coef_idx), int'(coef_val)});
      fir_taps[coef_idx] = int'(coef_val);
    end
    if (done === 1'b1) done_log.push_back(cyc);
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic step(input bit st, input bit ab, input bit v, input logic [7:0] d, output bit xf);
    start = st; abort = ab; in_valid = v; in_data = d;
    xf = v && in_ready && !ab;
    @(negedge clk);
  endtask

  task automatic clear_logs();
    wr_log.delete();
    done_log.delete();
    for (int i = 0; i < 16; i++) fir_taps[i] = 0;
  endtask

  task automatic fill_ramp(input int cs);
    tx_q.delete();
    for (int i = 1; i <= NT; i++) tx_q.push_back(8'(i));
    if (Chk) tx_q.push_back(8'(cs));
  endtask

  // mode 0: InValid held high; 1: alternating 1,0,...; abort_at >= 0 aborts after that many bytes.
  task automatic run_load(input int nbytes, input int mode, input int abort_at);
    bit xf;
    bit v;
    int sent  = 0;
    int guard = 0;
    step(1'b1, 1'b0, 1'b0, 8'h00, xf);
    while (sent < nbytes) begin
      if (guard > 300) begin
        checks++; failures++;
        $display("FAIL load_timeout: got %0d bytes want %0d", sent, nbytes);
        break;
      end
      guard++;
      v = (mode == 0) ? 1'b1 : (guard % 2 == 1);
      if (abort_at >= 0 && sent == abort_at) begin
        step(1'b0, 1'b1, 1'b1, tx_q[sent], xf);
        break;
      end
      step(1'b0, 1'b0, v, tx_q[sent], xf);
      if (xf) sent++;
    end
    repeat (4) step(1'b0, 1'b0, 1'b0, 8'h00, xf);
  endtask

  initial begin
    bit xf;
    int sent;
    int guard;
    rst_n = 1'b0; start = 1'b0; abort = 1'b0; in_valid = 1'b0; in_data = 8'h00;
    repeat (3) @(negedge clk);
    chk("rst_ready", in_ready, 1'b0);
    chk("rst_busy",  busy,     1'b0);
    chk("rst_we",    coef_we,  1'b0);
    chk("rst_done",  done,     1'b0);
    #2 rst_n = 1'b1;
    @(negedge clk);

    // Back-to-back ramp 1..10: contiguous strobes, Done right after the last one.
    clear_logs(); fill_ramp(201);
    run_load(NB, 0, -1);
    chk("r34_count", wr_log.size(), NT);
    for (int i = 0; i < wr_log.size() && i < NT; i++) begin
      chk("r34_idx", wr_log[i].idx, i);
      chk("r34_val", wr_log[i].val, i + 1);
      chk("r34_cyc", wr_log[i].cyc, wr_log[0].cyc + i);
      chk("r34_tap", fir_taps[i], i + 1);
    end
    chk("r34_done_cnt", done_log.size(), 1);
    if (done_log.size() > 0 && wr_log.size() == NT)
      chk("r34_done_cyc", done_log[0], wr_log[NT-1].cyc + 1);
`ifdef FIR_COEF_CHECKSUM_EN
    chk("r38_good_err", error, 1'b0);
`endif

    // InValid alternating: strobes only after transfers, indices still contiguous.
    clear_logs(); fill_ramp(201);
    run_load(NB, 1, -1);
    chk("r35_count", wr_log.size(), NT);
    for (int i = 0; i < wr_log.size() && i < NT; i++) chk("r35_idx", wr_log[i].idx, i);
    chk("r35_done_cnt", done_log.size(), 1);
`ifndef FIR_COEF_CHECKSUM_EN
    if (done_log.size() > 0 && wr_log.size() == NT)
      chk("r35_done_cyc", done_log[0], wr_log[NT-1].cyc + 1);
`endif

    // Abort once index 4 has been written, then a fresh load starts from 0.
    clear_logs(); fill_ramp(201);
    run_load(NB, 0, 5);
    chk("r36_count", wr_log.size(), 5);
    chk("r36_done_cnt", done_log.size(), 0);
    if (wr_log.size() > 0) chk("r36_last_idx", wr_log[wr_log.size()-1].idx, 4);
    clear_logs();
    run_load(NB, 0, -1);
    chk("r36_reload_cnt", wr_log.size(), NT);
    if (wr_log.size() > 0) chk("r36_reload_idx0", wr_log[0].idx, 0);

    // Reset while the index-6 strobe is high.
    clear_logs(); fill_ramp(201);
    step(1'b1, 1'b0, 1'b0, 8'h00, xf);
    sent = 0; guard = 0;
    while (sent < 7 && guard < 50) begin
      guard++;
      step(1'b0, 1'b0, 1'b1, tx_q[sent], xf);
      if (xf) sent++;
    end
    #2;
    chk("r37_we_before",  coef_we,  1'b1);
    chk("r37_idx_before", coef_idx, 6);
    rst_n = 1'b0;
    #1;
    chk("r37_we_after",    coef_we,  1'b0);
    chk("r37_busy_after",  busy,     1'b0);
    chk("r37_ready_after", in_ready, 1'b0);
    @(negedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
    repeat (3) begin
      step(1'b0, 1'b0, 1'b1, 8'h55, xf);
      chk("r37_ready_idle", in_ready, 1'b0);
    end
    chk("r37_done_cnt", done_log.size(), 0);
    chk("r37_wr_cnt", wr_log.size(), 7);

`ifdef FIR_COEF_CHECKSUM_EN
    // Bad checksum: Error with Done, held until the next Start.
    clear_logs(); fill_ramp(200);
    run_load(NB, 0, -1);
    chk("r38_bad_done", done_log.size(), 1);
    chk("r38_bad_err", error, 1'b1);
    repeat (5) step(1'b0, 1'b0, 1'b0, 8'h00, xf);
    chk("r38_err_held", error, 1'b1);
    step(1'b1, 1'b0, 1'b0, 8'h00, xf);
    chk("r38_err_clear", error, 1'b0);
    step(1'b0, 1'b1, 1'b0, 8'h00, xf);
    repeat (2) step(1'b0, 1'b0, 1'b0, 8'h00, xf);
`endif

    // Random traffic including stray Start/Abort and occasional resets.
    for (int c = 0; c < 2000; c++) begin
      if ($urandom_range(0, 299) == 0) begin
        #2 rst_n = 1'b0;
        @(negedge clk);
        #2 rst_n = 1'b1;
        @(negedge clk);
      end else begin
        step($urandom_range(0, 7) == 0, $urandom_range(0, 24) == 0,
             $urandom_range(0, 3) != 0, 8'($urandom), xf);
      end
    end
    repeat (4) step(1'b0, 1'b0, 1'b0, 8'h00, xf);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
